// File: rtl/ahb_slave_sram.sv
// AHB responder in front of a word-addressed SRAM: lane-merged writes, read-after-write
// forwarding, two-cycle ERROR response. Define AHB_SLAVE_WAIT_EN to honour WAIT_STATES.
module ahb_slave_sram #(
    parameter int          WDT         = 32,
    parameter int          DEPTH       = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic           i_hclk,
    input  logic           i_hreset_n,
    input  logic           i_hsel,
    input  logic [31:0]    i_haddr,
    input  logic [1:0]     i_htrans,
    input  logic           i_hwrite,
    input  logic [1:0]     i_hsize,
    input  logic [WDT-1:0] i_hwdata,
    input  logic           i_hready,
    output logic           o_hready,
    output logic [1:0]     o_hresp,
    output logic [WDT-1:0] o_hrdata
);
    localparam int          NB   = WDT / 8;
    localparam int          LB   = $clog2(NB);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * NB);

    localparam logic [1:0] S_IDLE = 2'd0;
`ifdef AHB_SLAVE_WAIT_EN
    localparam logic [1:0] S_WAIT = 2'd1;
`endif
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    function automatic logic [NB-1:0] lane_mask(input logic [1:0] size, input logic [LB-1:0] off);
        logic [NB-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            if ((i >= int'(off)) && (i < int'(off) + (32'sd1 <<< size))) m[i] = 1'b1;
            else m[i] = 1'b0;
        end
        return m;
    endfunction

    logic [WDT-1:0]    mem_q [DEPTH];
    logic [1:0]        state_q, state_d;
`ifdef AHB_SLAVE_WAIT_EN
    logic [3:0]        cnt_q, cnt_d;
`endif
    logic [LB+AW-1:0]  addr_q;
    logic              write_q;
    logic [1:0]        size_q;
    logic              pend_q;
    logic [WDT-1:0]    rdata_q;

    logic [31:0]       offset_s;
    logic [31:0]       align_mask_s;
    logic              illegal_s;
    logic              acc_s;
    logic              hready_s;
    logic [1:0]        hresp_s;
    logic              commit_s;
    logic [AW-1:0]     rd_idx_s;
    logic [AW-1:0]     wr_idx_s;
    logic [NB-1:0]     mask_s;
    logic [WDT-1:0]    merged_s;

    // Address decode and legality of the address phase currently on the bus
    always_comb begin
        offset_s     = i_haddr - BASE_ADDR;
        align_mask_s = (32'd1 << i_hsize) - 32'd1;
        illegal_s    = (offset_s >= SPAN) || ((i_haddr & align_mask_s) != 32'd0) ||
                       ((i_hsize == 2'd3) && (WDT == 32));
        acc_s        = i_hsel && i_hready && i_htrans[1] &&
                       ((state_q == S_IDLE) || (state_q == S_ERR2));
        rd_idx_s     = offset_s[LB +: AW];
        wr_idx_s     = addr_q[LB +: AW];
        mask_s       = lane_mask(size_q, addr_q[LB-1:0]);
        commit_s     = pend_q && write_q && hready_s;
    end

    // Byte-lane merge of write data over the currently stored word
    always_comb begin
        merged_s = mem_q[wr_idx_s];
        for (int b = 0; b < NB; b++) begin
            if (mask_s[b]) merged_s[8*b +: 8] = i_hwdata[8*b +: 8];
            else           merged_s[8*b +: 8] = mem_q[wr_idx_s][8*b +: 8];
        end
    end

    // State register
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state_q <= S_IDLE;
`ifdef AHB_SLAVE_WAIT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
`ifdef AHB_SLAVE_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state logic; a new transfer may start in S_ERR2 since it completes with hready high
    always_comb begin
        state_d = state_q;
`ifdef AHB_SLAVE_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE, S_ERR2: begin
                if (acc_s && illegal_s) begin
                    state_d = S_ERR1;
`ifdef AHB_SLAVE_WAIT_EN
                end else if (acc_s && (WAIT_STATES > 0)) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_STATES);
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef AHB_SLAVE_WAIT_EN
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
`endif
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode straight from the state flops
    always_comb begin
        case (state_q)
            S_IDLE: begin hready_s = 1'b1; hresp_s = 2'd0; end
`ifdef AHB_SLAVE_WAIT_EN
            S_WAIT: begin hready_s = 1'b0; hresp_s = 2'd0; end
`endif
            S_ERR1: begin hready_s = 1'b0; hresp_s = 2'd1; end
            S_ERR2: begin hready_s = 1'b1; hresp_s = 2'd1; end
            default: begin hready_s = 1'b1; hresp_s = 2'd0; end
        endcase
    end

    // Address-phase capture and registered read data (forwarded when a same-word write commits)
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            pend_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (i_hready) pend_q <= acc_s && !illegal_s;
            else          pend_q <= pend_q;
            if (acc_s) begin
                addr_q  <= offset_s[LB+AW-1:0];
                write_q <= i_hwrite;
                size_q  <= i_hsize;
            end else begin
                addr_q  <= addr_q;
                write_q <= write_q;
                size_q  <= size_q;
            end
            if (acc_s && !illegal_s && !i_hwrite) begin
                if (commit_s && (rd_idx_s == wr_idx_s)) rdata_q <= merged_s;
                else                                    rdata_q <= mem_q[rd_idx_s];
            end else begin
                rdata_q <= rdata_q;
            end
        end
    end

    // SRAM array, deliberately without reset
    always_ff @(posedge i_hclk) begin
        if (commit_s) mem_q[wr_idx_s] <= merged_s;
    end

    assign o_hready = hready_s;
    assign o_hresp  = hresp_s;
    assign o_hrdata = rdata_q;

endmodule

// File: tb/tb_ahb_slave_sram.sv
// Scoreboard bench for ahb_slave_sram: a byte-level memory model predicts read data,
// a negedge monitor checks every data phase for response, wait count and data.
module tb_ahb_slave_sram;
    localparam int WS = 3;
`ifdef AHB_SLAVE_WAIT_EN
    localparam int EXP_W = WS;
`else
    localparam int EXP_W = 0;
`endif

    typedef struct {
        logic        w;
        logic        err;
        logic [31:0] data;
    } sb_t;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        hsel     = 1'b0;
    logic [31:0] haddr    = 32'h0;
    logic [1:0]  htrans   = 2'd0;
    logic        hwrite   = 1'b0;
    logic [1:0]  hsize    = 2'd0;
    logic [31:0] hwdata   = 32'h0;
    logic        bus_ready;
    logic        o_hready;
    logic [1:0]  o_hresp;
    logic [31:0] o_hrdata;

    sb_t         sb [$];
    logic [7:0]  bmem [0:1023];
    int          n_vec = 0;
    int          n_err = 0;

    assign bus_ready = o_hready;

    ahb_slave_sram #(.WDT(32), .DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(WS)) u_dut (
        .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata),
        .i_hready(bus_ready), .o_hready(o_hready), .o_hresp(o_hresp), .o_hrdata(o_hrdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int w;
        w = int'(a) & ~3;
        return {bmem[w+3], bmem[w+2], bmem[w+1], bmem[w]};
    endfunction

    // Drive one address phase, wait for its acceptance, then present its write data
    task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] d, input bit err);
        sb_t e;
        bit  rdy;
        int  n;
        hsel = 1'b1; htrans = 2'd2; hwrite = w; haddr = a; hsize = sz;
        rdy = 1'b0;
        n = 0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = o_hready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) check_eq("accept_timeout", 64'd0, 64'd1);
        hwdata = d; htrans = 2'd0; hsel = 1'b0;
        e.w = w; e.err = err; e.data = 32'h0;
        if (!err && w) begin
            for (int i = 0; i < (1 << sz); i++) bmem[a+i] = d[8*((a+i)%4) +: 8];
        end
        if (!err && !w) e.data = model_read(a);
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        hsel = 1'b0; htrans = 2'd0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        hsel = 1'b0; htrans = 2'd0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain", 64'(sb.size()), 64'd0);
    endtask

    // Data-phase monitor: counts low-hready cycles and checks each completion
    initial begin : monitor
        int  wcnt;
        sb_t e;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (rst_n && sb.size() > 0) begin
                if (!o_hready) begin
                    wcnt++;
                    check_eq(sb[0].err ? "err1_resp" : "wait_resp", 64'(o_hresp),
                             sb[0].err ? 64'd1 : 64'd0);
                    if (wcnt > 40) begin
                        check_eq("wait_timeout", 64'(wcnt), 64'd0);
                        e = sb.pop_front();
                        wcnt = 0;
                    end
                end else begin
                    e = sb.pop_front();
                    check_eq("resp", 64'(o_hresp), e.err ? 64'd1 : 64'd0);
                    check_eq("wait_cycles", 64'(wcnt), e.err ? 64'd1 : 64'(EXP_W));
                    if (!e.w && !e.err) check_eq("rdata", 64'(o_hrdata), 64'(e.data));
                    wcnt = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] ra [8];
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_hready", 64'(o_hready), 64'd1);
        check_eq("rst_hresp", 64'(o_hresp), 64'd0);
        check_eq("rst_hrdata", 64'(o_hrdata), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // word write then pipelined read (forwarded), then a plain read
        issue(1'b1, 32'h10, 2'd2, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
        idle(2);
        issue(1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
        // byte and halfword lane merging
        issue(1'b1, 32'h10, 2'd2, 32'h11223344, 1'b0);
        idle(1);
        issue(1'b1, 32'h13, 2'd0, 32'hAAAAAAAA, 1'b0);
        idle(1);
        issue(1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
        issue(1'b1, 32'h20, 2'd2, 32'h01020304, 1'b0);
        issue(1'b1, 32'h22, 2'd1, 32'hBEEFBEEF, 1'b0);
        issue(1'b0, 32'h20, 2'd2, 32'h0, 1'b0);
        // error responses, next transfer accepted in S_ERR2, array untouched
        issue(1'b1, 32'h0, 2'd2, 32'hCAFEF00D, 1'b0);
        issue(1'b1, 32'h400, 2'd2, 32'hFFFFFFFF, 1'b1);
        issue(1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
        idle(2);
        issue(1'b1, 32'h1, 2'd1, 32'hFFFFFFFF, 1'b1);
        issue(1'b1, 32'h8, 2'd3, 32'hFFFFFFFF, 1'b1);
        issue(1'b0, 32'h0, 2'd2, 32'h0, 1'b0);
        drain();
        // unselected NONSEQ and selected BUSY must not write
        hsel = 1'b0; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h10; hsize = 2'd2;
        @(posedge clk); #1;
        hsel = 1'b1; htrans = 2'd1; hwdata = 32'h0;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0;
        @(posedge clk); #1;
        issue(1'b0, 32'h10, 2'd2, 32'h0, 1'b0);
        // forwarding of a write to the immediately following read
        issue(1'b1, 32'h20, 2'd2, 32'h5A5A5A5A, 1'b0);
        issue(1'b0, 32'h20, 2'd2, 32'h0, 1'b0);
        // random word writes then read-back
        for (int k = 0; k < 8; k++) begin
            ra[k] = 32'h100 + 32'(4 * $urandom_range(0, 63));
            issue(1'b1, ra[k], 2'd2, $urandom, 1'b0);
        end
        for (int k = 0; k < 8; k++) issue(1'b0, ra[k], 2'd2, 32'h0, 1'b0);
        // reset during the data phase of a write aborts it
        issue(1'b1, 32'h40, 2'd2, 32'h11111111, 1'b0);
        issue(1'b0, 32'h40, 2'd2, 32'h0, 1'b0);
        drain();
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h40; hsize = 2'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0; hwdata = 32'h22222222;
        rst_n = 1'b0;
        #1;
        check_eq("arst_hready", 64'(o_hready), 64'd1);
        check_eq("arst_hresp", 64'(o_hresp), 64'd0);
        check_eq("arst_hrdata", 64'(o_hrdata), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b0, 32'h40, 2'd2, 32'h0, 1'b0);
        drain();
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ahb_slave_sram.md
# ahb_slave_sram

AHB responder holding a word-addressed internal SRAM. It is the far end of the bus from the AHB master pipeline. It samples address phases, inserts programmable wait states, and commits byte/halfword/word(/doubleword) writes with per-lane merging. Reads return from the array, and illegal accesses get a two-cycle ERROR response. It serves as the standard bus target for master bring-up and as a local scratchpad.

## Interface
- WDT, 32, data bus width; 32 or 64 only.
- DEPTH, 256, array depth in WDT-bit words; power of two.
- BASE_ADDR, 32'h0000_0000, byte base address; aligned to DEPTH*WDT/8.
- WAIT_STATES, 0, wait cycles per data phase, 0..15; honoured only with AHB_SLAVE_WAIT_EN.
- i_hclk  input  1  bus clock; all state on rising edge.
- i_hreset_n  input  1  reset; asynchronous assert, active-low.
- i_hsel  input  1  slave select, address-phase qualifier.
- i_haddr  input  32  byte address.
- i_htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- i_hwrite  input  1  1=write.
- i_hsize  input  2  0=byte, 1=half, 2=word, 3=dword.
- i_hwdata  input  WDT  write data, data phase.
- i_hready  input  1  bus HREADY (muxed); address phase sampled only when 1.
- o_hready  output  1  data-phase complete; reset 1.
- o_hresp  output  2  OKAY=0, ERROR=1 (RETRY/SPLIT never driven); reset OKAY.
- o_hrdata  output  WDT  read data; reset 0.

## Operation
- Address phase is accepted when i_hsel && i_hready && i_htrans[1]. Accepting registers addr, write, size and a pending flag. An unaccepted cycle with i_hready=1 clears pending.
- An access is illegal if any of these hold:
  - offset = haddr-BASE_ADDR >= DEPTH*WDT/8;
  - haddr is not aligned to 2^hsize;
  - hsize=3 with WDT=32.
- FSM states:
  - S_IDLE: o_hready=1, OKAY.
  - S_WAIT: o_hready=0, OKAY, counter running.
  - S_ERR1: o_hready=0, ERROR.
  - S_ERR2: o_hready=1, ERROR.
- Transitions:
  - Accepted illegal access: next state S_ERR1, then S_ERR2, then S_IDLE. A new address phase may be accepted in S_ERR2.
  - Accepted legal access with WAIT_STATES=N>0: next state S_WAIT with counter=N. Decrement each cycle. Return to S_IDLE when the counter reaches 1, so o_hready is low for exactly N cycles and then high for one cycle.
  - Legal access with N=0: stay in S_IDLE. The data phase completes in the cycle after the address phase.
  - BUSY/IDLE transfers and unselected cycles: zero-wait OKAY, no array access.
- Write commit:
  - Happens in the data-phase completion cycle (o_hready=1, pending legal write). i_hwdata is sampled at that edge.
  - Only the lanes selected by hsize and haddr[log2(WDT/8)-1:0] are updated; other bytes are preserved.
- Read:
  - The array is indexed by the address-phase address. The registered word is driven on o_hrdata and held through waits until the completion cycle.
  - Full word returned; lane selection is the master's job.
  - o_hrdata holds its last value on non-read cycles.
- Read-after-write forwarding: a read whose address phase coincides with a committing write to the same word must return the merged new data.
- Array contents are not reset. Reset aborts any pending write (not committed), returns to S_IDLE, and clears pending.

## Timing
- Zero-wait read latency: address phase in cycle T, o_hrdata valid with o_hready=1 in cycle T+1.
- With N waits: o_hready=0 in T+1..T+N; completion in T+N+1.
- Back-to-back accepted transfers sustain one per cycle at N=0.
- ERROR: o_hresp=ERROR in both S_ERR1 and S_ERR2; o_hready 0 then 1.
- Outputs are registered. No combinational path from inputs to o_hready or o_hresp.

## Configuration
- AHB_SLAVE_WAIT_EN:
  - Defined: WAIT_STATES is honoured and S_WAIT exists.
  - Undefined: S_WAIT and the counter are compiled out, and every legal transfer is zero-wait regardless of WAIT_STATES. Error sequencing is unchanged.

## Test plan
- Zero-wait word write then read at 0x10, WAIT_STATES=0, wdata 0xDEADBEEF -> read completes in the next cycle with o_hrdata=0xDEADBEEF, OKAY.
- Byte write 0xAA to 0x13 over word 0x11223344 -> read of 0x10 returns 0xAA223344.
- WAIT_STATES=3 (macro defined) read -> o_hready low for exactly 3 cycles, high on the 4th with data. With the macro undefined -> zero-wait.
- Access at offset DEPTH*4 (WDT=32) or halfword at 0x1 -> ERROR with o_hready 0 then 1, array unchanged, next NONSEQ accepted in S_ERR2.
- Write 0x5A5A5A5A to 0x20 followed immediately by a pipelined read of 0x20 -> read returns 0x5A5A5A5A (forwarding).
- i_hreset_n asserted during S_WAIT of a write -> o_hready=1, OKAY, o_hrdata=0 immediately; target word keeps its old value.
